// File: rtl/successive_approx_search_pkg.sv
// rtl/successive_approx_search_pkg.sv - shared types for the successive-approximation search
package successive_approx_search_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/successive_approx_search.sv
// rtl/successive_approx_search.sv - finds a hidden signed value bit by bit via an external >= comparator
module successive_approx_search
  import successive_approx_search_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic signed [N-1:0] result,
  output logic                cmp_req,
  output logic signed [N-1:0] probe,
  input  logic                cmp_ack,
  input  logic                cmp_ge
);

  localparam int            KW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0]  MSB   = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]  ONE   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [KW-1:0] K_TOP = KW'(N - 1);

  state_t        state, state_next;
  logic [N-1:0]  acc;
  logic [N-1:0]  trial;
  logic [N-1:0]  acc_next;
  logic [KW-1:0] k;
  logic          last_bit;

  // The search runs in offset binary so an unsigned bit-by-bit build maps onto signed order.
  assign trial    = acc | (ONE << k);
  assign acc_next = cmp_ge ? trial : acc;
  assign probe    = trial ^ MSB;
  assign last_bit = (k == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = REQ;
      REQ:     if (cmp_ack && last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    cmp_req = 1'b0;
    case (state)
      REQ: begin
        busy    = 1'b1;
        cmp_req = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // result is captured with the final decision so it is already valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      k      <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            k   <= K_TOP;
          end
        end
        REQ: begin
          if (cmp_ack) begin
            acc <= acc_next;
            if (last_bit) result <= acc_next ^ MSB;
            else          k      <= k - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
